axis_rx_fifo: RTL and testbench
===============================

// Module: axis_rx_fifo
// PURPOSE
//  AXI4-Stream receive FIFO. Sits directly upstream of the AXI VIP example design (ex_sim) in the rx_fifo_axis chip.
//  Buffers inbound beats and presents them to the AXI master stage; reports fill level and completed-packet count.
//  In packet mode it forwards a packet only once its tlast beat is stored (store-and-forward).
// PARAMETERS
//  DATA_W    32  tdata width in bits (multiple of 8)
//  DEPTH     16  storage entries; power of 2, >= 4
//  PKT_MODE  0   0 = cut-through, 1 = store-and-forward on tlast
// PORTS
//  aclk           in   1            single clock; all logic on rising edge
//  areset         in   1            asynchronous, active-high reset
//  s_axis_tdata   in   DATA_W       inbound beat data
//  s_axis_tvalid  in   1            inbound beat valid
//  s_axis_tready  out  1            FIFO accepts beat
//  s_axis_tlast   in   1            inbound end of packet
//  m_axis_tdata   out  DATA_W       outbound beat data
//  m_axis_tvalid  out  1            outbound beat valid
//  m_axis_tready  in   1            downstream accepts beat
//  m_axis_tlast   out  1            outbound end of packet
//  level          out  AW+1         words held, 0..DEPTH (AW = clog2(DEPTH))
//  pkt_count      out  AW+1         complete packets held (tlast beats stored, not yet read)
//  full           out  1            level == DEPTH
//  empty          out  1            level == 0
//  pkt_err        out  1            sticky: store-and-forward deadlock release occurred
// BEHAVIOUR
//  Reset (async assert, sync release): level=0, pkt_count=0, pkt_err=0, m_axis_tvalid=0, full=0, empty=1.
//   - s_axis_tready=0 while areset high. Contents are discarded; a packet in flight when reset is asserted is lost.
//  Write: beat accepted when s_axis_tvalid && s_axis_tready. s_axis_tready = !areset && level < DEPTH.
//   - When full, a same-cycle read does NOT enable a write; tready returns the cycle after level drops.
//  Read: beat consumed when m_axis_tvalid && m_axis_tready.
//   - FWFT output register, so m_axis_tdata/tlast are stable while tvalid=1 and tready=0.
//  Latency: beat written at edge N appears with m_axis_tvalid=1 after edge N+1 (1 cycle), cut-through mode.
//   - Full throughput: 1 beat/cycle in and out simultaneously when 0 < level < DEPTH.
//  level: +1 on write, -1 on read, unchanged on both. Includes the output-register entry. Never exceeds DEPTH.
//  Pointers: AW-bit wrap naturally at DEPTH; wrap is invisible externally (no bubble).
//  pkt_count: +1 on write with tlast, -1 on read with tlast, unchanged on both.
//  PKT_MODE=1 gating: m_axis_tvalid only while gate_open. Gate state machine:
//   - HOLD: gate closed.
//     - -> FWD when pkt_count > 0.
//     - -> REL when full && pkt_count == 0, i.e. packet > DEPTH; this transition sets pkt_err.
//   - FWD: gate open. -> HOLD on read of a tlast beat when pkt_count == 1 (after decrement 0, no incoming tlast same cycle).
//   - REL: gate open, cut-through until the oversize packet's tlast is read, then -> HOLD or FWD per pkt_count.
//  Gate latency: tlast written at edge N gives m_axis_tvalid=1 after edge N+2 (count update plus output register).
//  PKT_MODE=0: gate is always open, and the state machine is optimised away.
//  pkt_err clears only on reset.
//  No data is ever dropped or duplicated. Beat order and tlast positions are preserved exactly.
// STRUCTURE
//  Package axis_fifo_pkg:
//   - clog2-based AW helper
//   - typedef struct packed {logic last; logic [DATA_W-1:0] data;} entry type (parameterised via function/macro)
//   - enum gate_state_t {HOLD, FWD, REL}
//  Sub-module fifo_ram_dp: simple dual-port RAM, DEPTH x (DATA_W+1), sync write, sync read.
//  Top holds pointers, level/pkt counters, the FWFT output register and the gate FSM.
// TESTING
//  1. Reset then idle -> empty=1, level=0, s_axis_tready=1, m_axis_tvalid=0. Hold 20 cycles.
//  2. Cut-through: write 0xA5A5_0001 at edge N with m_tready=1 -> m_tvalid=1 with that data after N+1; level back to 0.
//  3. Fill: 16 writes, m_tready=0 -> full=1, level=16, s_tready=0.
//     - Then 1 read -> s_tready=1 the next cycle.
//     - Data order 0..15 is preserved.
//  4. Streaming: 1000 random beats, random tvalid/tready (50%) -> output equals input incl. tlast; level never >16.
//  5. PKT_MODE=1: 3-beat packet with m_tready=1 -> no m_tvalid until tlast written.
//     - Then the beats stream; pkt_count goes 1 -> 0.
//     - 20-beat packet -> pkt_err=1 at full and the packet is released intact.
//  6. Assert areset mid-packet, level=5 -> level=0, m_tvalid=0 asynchronously.
//     - A new 2-beat packet is then received correctly.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// Shared types and sizing helpers for the AXI4-Stream receive FIFO.
package axis_fifo_pkg;

  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

  // Width of one stored beat: tdata plus the tlast flag.
  function automatic int entry_w(input int data_w);
    return data_w + 1;
  endfunction

  typedef enum logic [1:0] {
    HOLD,
    FWD,
    REL
  } gate_state_t;

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port with enable.
module fifo_ram_dp
  import axis_fifo_pkg::*;
#(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 16,
  localparam int AW    = aw_of(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The read register only advances on re_i, so it doubles as the FWFT output data register.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/axis_rx_fifo.sv
// AXI4-Stream receive FIFO with FWFT output, fill/packet counters and optional store-and-forward gate.
module axis_rx_fifo
  import axis_fifo_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int DEPTH    = 16,
  parameter  int PKT_MODE = 0,
  localparam int AW       = aw_of(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [AW:0]       level,
  output logic [AW:0]       pkt_count,
  output logic              full,
  output logic              empty,
  output logic              pkt_err
);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  entry_t        wr_entry, rd_entry;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d, pkt_count_q, pkt_count_d;
  logic          valid_q, valid_d;
  logic          wr_fire, rd_fire, wr_last, rd_last;
  logic          ram_has, fetch, gate_open, pkt_err_q;

  assign full          = (level_q == DEPTH_L);
  assign empty         = (level_q == '0);
  assign s_axis_tready = !areset && !full;
  assign wr_fire       = s_axis_tvalid && s_axis_tready;
  assign rd_fire       = valid_q && m_axis_tready;
  assign wr_last       = wr_fire && s_axis_tlast;
  assign rd_last       = rd_fire && rd_entry.last;

  // level also counts the beat parked in the output register, so RAM-resident beats = level - valid.
  assign ram_has = (level_q != {{AW{1'b0}}, valid_q});
  assign fetch   = ram_has && (!valid_q || rd_fire) && gate_open;

  assign wr_entry = '{last: s_axis_tlast, data: s_axis_tdata};

  fifo_ram_dp #(
    .WIDTH (entry_w(DATA_W)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .re_i    (fetch),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    wr_ptr_d    = wr_fire ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = fetch ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d     = level_q;
    pkt_count_d = pkt_count_q;
    valid_d     = valid_q;
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + CNT_ONE;
      2'b01:   level_d = level_q - CNT_ONE;
      default: level_d = level_q;
    endcase
    case ({wr_last, rd_last})
      2'b10:   pkt_count_d = pkt_count_q + CNT_ONE;
      2'b01:   pkt_count_d = pkt_count_q - CNT_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
    if (fetch)        valid_d = 1'b1;
    else if (rd_fire) valid_d = 1'b0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
      valid_q     <= valid_d;
    end
  end

  generate
    if (PKT_MODE != 0) begin : g_gate
      gate_state_t state_q, state_d;
      logic        pkt_err_d;

      always_comb begin
        state_d   = state_q;
        pkt_err_d = pkt_err_q;
        case (state_q)
          HOLD: begin
            if (pkt_count_q != '0) begin
              state_d = FWD;
            end else if (full) begin
              // Packet larger than the FIFO: release it cut-through rather than deadlock.
              state_d   = REL;
              pkt_err_d = 1'b1;
            end
          end
          FWD:     if (rd_last && pkt_count_d == '0) state_d = HOLD;
          REL:     if (rd_last) state_d = (pkt_count_d != '0) ? FWD : HOLD;
          default: state_d = HOLD;
        endcase
      end

      always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
          state_q   <= HOLD;
          pkt_err_q <= 1'b0;
        end else begin
          state_q   <= state_d;
          pkt_err_q <= pkt_err_d;
        end
      end

      // Open only when open now and next cycle, so the output register never loads a beat of an incomplete packet.
      assign gate_open = (state_q != HOLD) && (state_d != HOLD);
    end else begin : g_thru
      assign gate_open = 1'b1;
      assign pkt_err_q = 1'b0;
    end
  endgenerate

  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = rd_entry.data;
  assign m_axis_tlast  = rd_entry.last;
  assign level         = level_q;
  assign pkt_count     = pkt_count_q;
  assign pkt_err       = pkt_err_q;

endmodule

// File: tb/tb_axis_rx_fifo.sv
// Directed bench: a cut-through instance and a store-and-forward instance share clock and reset.
module tb_axis_rx_fifo;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [31:0] c_tdata, c_mdata, p_tdata, p_mdata;
  logic        c_tvalid, c_sready, c_tlast, c_mvalid, c_mready, c_mlast, c_full, c_empty, c_err;
  logic        p_tvalid, p_sready, p_tlast, p_mvalid, p_mready, p_mlast, p_full, p_empty, p_err;
  logic [4:0]  c_level, c_pkt, p_level, p_pkt;

  int checks = 0;
  int errors = 0;

  axis_rx_fifo #(.DATA_W(32), .DEPTH(16), .PKT_MODE(0)) u_ct (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(c_tdata), .s_axis_tvalid(c_tvalid), .s_axis_tready(c_sready), .s_axis_tlast(c_tlast),
    .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid), .m_axis_tready(c_mready), .m_axis_tlast(c_mlast),
    .level(c_level), .pkt_count(c_pkt), .full(c_full), .empty(c_empty), .pkt_err(c_err)
  );

  axis_rx_fifo #(.DATA_W(32), .DEPTH(16), .PKT_MODE(1)) u_sf (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(p_tdata), .s_axis_tvalid(p_tvalid), .s_axis_tready(p_sready), .s_axis_tlast(p_tlast),
    .m_axis_tdata(p_mdata), .m_axis_tvalid(p_mvalid), .m_axis_tready(p_mready), .m_axis_tlast(p_mlast),
    .level(p_level), .pkt_count(p_pkt), .full(p_full), .empty(p_empty), .pkt_err(p_err)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [32:0] q[$];
  logic [32:0] exp_beat;
  int          sent, got, rcv, cyc;
  logic        lvl_bad, saw_full, early;

  initial begin
    c_tdata = '0; c_tvalid = 1'b0; c_tlast = 1'b0; c_mready = 1'b0;
    p_tdata = '0; p_tvalid = 1'b0; p_tlast = 1'b0; p_mready = 1'b0;

    // Reset and idle
    #1;
    check("rst_sready", c_sready, 0);
    check("rst_mvalid", c_mvalid, 0);
    check("rst_level", c_level, 0);
    check("rst_empty", c_empty, 1);
    check("rst_full", c_full, 0);
    check("rst_err", p_err, 0);
    repeat (3) step();
    areset = 1'b0;
    repeat (20) step();
    check("idle_empty", c_empty, 1);
    check("idle_level", c_level, 0);
    check("idle_sready", c_sready, 1);
    check("idle_mvalid", c_mvalid, 0);
    check("idle_p_sready", p_sready, 1);

    // Cut-through single beat
    c_tdata = 32'hA5A5_0001; c_tvalid = 1'b1; c_tlast = 1'b1; c_mready = 1'b1;
    step();
    c_tvalid = 1'b0; c_tlast = 1'b0;
    check("ct_lvl1", c_level, 1);
    check("ct_notyet", c_mvalid, 0);
    check("ct_pkt1", c_pkt, 1);
    step();
    check("ct_beat", {c_mvalid, c_mlast, c_mdata}, {1'b1, 1'b1, 32'hA5A5_0001});
    step();
    check("ct_mvalid0", c_mvalid, 0);
    check("ct_lvl0", c_level, 0);
    check("ct_pkt0", c_pkt, 0);

    // Fill to full, blocked write, single read, drain
    c_mready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c_tvalid = 1'b1; c_tdata = 32'(i); c_tlast = (i == 15);
      step();
    end
    c_tvalid = 1'b1; c_tdata = 32'hDEAD; c_tlast = 1'b0;
    check("fill_full", c_full, 1);
    check("fill_level", c_level, 16);
    check("fill_sready", c_sready, 0);
    check("fill_head", {c_mvalid, c_mdata}, {1'b1, 32'h0});
    step();
    check("full_hold", c_level, 16);
    c_mready = 1'b1;
    step();
    c_tvalid = 1'b0;
    check("read1_level", c_level, 15);
    check("read1_sready", c_sready, 1);
    for (int i = 1; i < 16; i++) begin
      check("drain", {c_mvalid, c_mlast, c_mdata}, {1'b1, (i == 15), 32'(i)});
      step();
    end
    check("drain_empty", c_empty, 1);
    check("drain_pkt", c_pkt, 0);

    // Random streaming
    sent = 0; got = 0; cyc = 0; lvl_bad = 1'b0;
    while (got < 1000 && cyc < 20000) begin
      c_tvalid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      c_tdata  = $urandom;
      c_tlast  = ($urandom_range(0, 3) == 0);
      c_mready = ($urandom_range(0, 1) == 1);
      if (c_level > 5'd16) lvl_bad = 1'b1;
      if (c_tvalid && c_sready) begin
        q.push_back({c_tlast, c_tdata});
        sent++;
      end
      if (c_mvalid && c_mready) begin
        exp_beat = q.pop_front();
        check("stream", {c_mlast, c_mdata}, exp_beat);
        got++;
      end
      step();
      cyc++;
    end
    c_tvalid = 1'b0; c_mready = 1'b0;
    check("stream_done", got, 1000);
    check("stream_level_bound", lvl_bad, 0);
    check("stream_level0", c_level, 0);
    check("stream_pkt0", c_pkt, 0);

    // Store-and-forward: 3-beat packet
    p_mready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_tvalid = 1'b1; p_tdata = 32'h100 + 32'(i); p_tlast = (i == 2);
      step();
      check("sf_hold", p_mvalid, 0);
    end
    p_tvalid = 1'b0; p_tlast = 1'b0;
    check("sf_pkt1", p_pkt, 1);
    step();
    check("sf_gate_lat", p_mvalid, 0);
    step();
    check("sf_b0", {p_mvalid, p_mlast, p_mdata}, {1'b1, 1'b0, 32'h100});
    step();
    check("sf_b1", {p_mvalid, p_mlast, p_mdata}, {1'b1, 1'b0, 32'h101});
    step();
    check("sf_b2", {p_mvalid, p_mlast, p_mdata}, {1'b1, 1'b1, 32'h102});
    check("sf_pkt_still1", p_pkt, 1);
    step();
    check("sf_done_valid", p_mvalid, 0);
    check("sf_done_pkt", p_pkt, 0);
    check("sf_done_level", p_level, 0);
    check("sf_no_err", p_err, 0);

    // Store-and-forward: 20-beat oversize packet
    sent = 0; rcv = 0; cyc = 0; saw_full = 1'b0; early = 1'b0;
    while (rcv < 20 && cyc < 200) begin
      p_tvalid = (sent < 20);
      p_tdata  = 32'h200 + 32'(sent);
      p_tlast  = (sent == 19);
      if (p_full) saw_full = 1'b1;
      if (p_mvalid && !saw_full) early = 1'b1;
      if (p_tvalid && p_sready) sent++;
      if (p_mvalid && p_mready) begin
        check("ovr_data", {p_mlast, p_mdata}, {(rcv == 19), 32'h200 + 32'(rcv)});
        rcv++;
      end
      step();
      cyc++;
    end
    p_tvalid = 1'b0; p_tlast = 1'b0;
    check("ovr_count", rcv, 20);
    check("ovr_saw_full", saw_full, 1);
    check("ovr_no_early", early, 0);
    check("ovr_err", p_err, 1);
    check("ovr_level0", p_level, 0);
    check("ovr_pkt0", p_pkt, 0);
    check("ovr_idle", p_mvalid, 0);

    // Reset mid-packet
    c_mready = 1'b0; p_mready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c_tvalid = 1'b1; c_tdata = 32'h400 + 32'(i); c_tlast = 1'b0;
      p_tvalid = 1'b1; p_tdata = 32'h500 + 32'(i); p_tlast = 1'b0;
      step();
    end
    c_tvalid = 1'b0; p_tvalid = 1'b0;
    check("pre_rst_c_level", c_level, 5);
    check("pre_rst_c_mvalid", c_mvalid, 1);
    check("pre_rst_p_level", p_level, 5);
    check("pre_rst_err_sticky", p_err, 1);
    #2 areset = 1'b1;
    #1;
    check("arst_c_level", c_level, 0);
    check("arst_c_mvalid", c_mvalid, 0);
    check("arst_c_sready", c_sready, 0);
    check("arst_p_level", p_level, 0);
    check("arst_p_err", p_err, 0);
    step();
    areset = 1'b0;
    step();

    // New 2-beat packet after reset
    p_mready = 1'b1;
    p_tvalid = 1'b1; p_tdata = 32'h600; p_tlast = 1'b0;
    step();
    p_tdata = 32'h601; p_tlast = 1'b1;
    step();
    p_tvalid = 1'b0; p_tlast = 1'b0;
    check("post_pkt1", p_pkt, 1);
    check("post_lvl2", p_level, 2);
    step();
    check("post_gate", p_mvalid, 0);
    step();
    check("post_b0", {p_mvalid, p_mlast, p_mdata}, {1'b1, 1'b0, 32'h600});
    step();
    check("post_b1", {p_mvalid, p_mlast, p_mdata}, {1'b1, 1'b1, 32'h601});
    step();
    check("post_idle", p_mvalid, 0);
    check("post_level0", p_level, 0);
    check("post_err", p_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
